// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl: top-level whack-a-mole sequencer.
// Generates the game-second time base, drives the countdown timer controls,
// picks mole positions from an 8-bit LFSR, judges hits/misses and keeps score.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   start              debounced start button (rising edge used)
//   pause_sw           debounced pause switch (level)
//   btn[3:0]           debounced hole buttons (rising edges used)
//   timer_done         countdown expired, from game timer
//   timer_enable       high in SPAWN, MOLE_UP and PAUSED
//   timer_hold         low only on the sec_tick cycle
//   timer_clr          1-cycle reload pulse for the game timer
//   sec_tick           1-cycle pulse every TICK_DIV running cycles
//   mole_mask[3:0]     one-hot active mole, 0 when none is up
//   score[3:0]         hit count, saturating at 15
//   hit_pulse          1-cycle pulse on a valid hit
//   miss_pulse         1-cycle pulse on a wrong button or mole timeout
//   game_over          high in OVER
module whack_game_ctrl #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned MOLE_TICKS = 2,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause_sw,
    input  logic [3:0] btn,
    input  logic       timer_done,
    output logic       timer_enable,
    output logic       timer_hold,
    output logic       timer_clr,
    output logic       sec_tick,
    output logic [3:0] mole_mask,
    output logic [3:0] score,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       game_over
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MC_W  = $clog2(MOLE_TICKS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SPAWN  = 3'd1;
    localparam logic [2:0] S_MOLE   = 3'd2;
    localparam logic [2:0] S_PAUSED = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [2:0]       ret_q, ret_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [MC_W-1:0]  mole_cnt_q, mole_cnt_d;
    logic             start_prev_q;
    logic [3:0]       btn_prev_q;
    logic [1:0]       prev_pos_q, prev_pos_d;

    logic             timer_enable_q, timer_enable_d;
    logic             timer_hold_q, timer_hold_d;
    logic             timer_clr_q, timer_clr_d;
    logic             sec_tick_q, sec_tick_d;
    logic [3:0]       mole_mask_q, mole_mask_d;
    logic [3:0]       score_q, score_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic             game_over_q, game_over_d;

    logic             start_edge;
    logic [3:0]       btn_edge;
    logic             run;
    logic             tick;
    logic [1:0]       pos;

    assign start_edge = start & ~start_prev_q;
    assign btn_edge   = btn & ~btn_prev_q;

    // Time base only advances while actively playing; pause and game end stop it.
    assign run  = ((state_q == S_SPAWN) || (state_q == S_MOLE)) && !pause_sw && !timer_done;
    assign tick = run && (div_q == DIV_W'(TICK_DIV - 1));

    // Spawn position; nudge by one if it would repeat the previous hole.
    always_comb begin
        pos = lfsr_q[1:0];
        if (lfsr_q[1:0] == prev_pos_q) begin
            pos = lfsr_q[1:0] + 2'd1;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        mole_mask_d = mole_mask_q;
        score_d     = score_q;
        mole_cnt_d  = mole_cnt_q;
        prev_pos_d  = prev_pos_q;
        timer_clr_d = 1'b0;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        div_d = div_q;
        if (run) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end else if ((state_q == S_IDLE) || (state_q == S_OVER) || timer_done) begin
            div_d = '0;
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                mole_mask_d = 4'd0;
                if (start_edge) begin
                    state_d     = S_SPAWN;
                    timer_clr_d = 1'b1;
                    score_d     = 4'd0;
                end
            end
            S_SPAWN: begin
                if (timer_done) begin
                    state_d     = S_OVER;
                    mole_mask_d = 4'd0;
                end else if (pause_sw) begin
                    state_d = S_PAUSED;
                    ret_d   = S_SPAWN;
                end else begin
                    mole_mask_d = 4'(4'b0001 << pos);
                    prev_pos_d  = pos;
                    mole_cnt_d  = '0;
                    state_d     = S_MOLE;
                end
            end
            S_MOLE: begin
                if (timer_done) begin
                    state_d     = S_OVER;
                    mole_mask_d = 4'd0;
                end else if (pause_sw) begin
                    state_d = S_PAUSED;
                    ret_d   = S_MOLE;
                end else if ((btn_edge & mole_mask_q) != 4'd0) begin
                    hit_d       = 1'b1;
                    score_d     = (score_q == 4'hF) ? 4'hF : score_q + 4'd1;
                    mole_mask_d = 4'd0;
                    state_d     = S_SPAWN;
                end else if (tick && (mole_cnt_q == MC_W'(MOLE_TICKS - 1))) begin
                    miss_d      = 1'b1;
                    mole_mask_d = 4'd0;
                    state_d     = S_SPAWN;
                end else begin
                    if (tick) begin
                        mole_cnt_d = mole_cnt_q + MC_W'(1);
                    end
                    if (btn_edge != 4'd0) begin
                        miss_d = 1'b1;
                    end
                end
            end
            S_PAUSED: begin
                if (timer_done) begin
                    state_d     = S_OVER;
                    mole_mask_d = 4'd0;
                end else if (!pause_sw) begin
                    state_d = ret_q;
                end
            end
            default: begin
                state_d     = S_IDLE;
                mole_mask_d = 4'd0;
            end
        endcase

        // Status outputs are registered against the next state so they line up with it.
        timer_enable_d = (state_d == S_SPAWN) || (state_d == S_MOLE) || (state_d == S_PAUSED);
        game_over_d    = (state_d == S_OVER);
        sec_tick_d     = tick;
        timer_hold_d   = ~tick;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ret_q          <= S_IDLE;
            lfsr_q         <= LFSR_SEED;
            div_q          <= '0;
            mole_cnt_q     <= '0;
            start_prev_q   <= 1'b0;
            btn_prev_q     <= 4'd0;
            prev_pos_q     <= 2'd0;
            timer_enable_q <= 1'b0;
            timer_hold_q   <= 1'b1;
            timer_clr_q    <= 1'b0;
            sec_tick_q     <= 1'b0;
            mole_mask_q    <= 4'd0;
            score_q        <= 4'd0;
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            lfsr_q         <= lfsr_d;
            div_q          <= div_d;
            mole_cnt_q     <= mole_cnt_d;
            start_prev_q   <= start;
            btn_prev_q     <= btn;
            prev_pos_q     <= prev_pos_d;
            timer_enable_q <= timer_enable_d;
            timer_hold_q   <= timer_hold_d;
            timer_clr_q    <= timer_clr_d;
            sec_tick_q     <= sec_tick_d;
            mole_mask_q    <= mole_mask_d;
            score_q        <= score_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
            game_over_q    <= game_over_d;
        end
    end

    assign timer_enable = timer_enable_q;
    assign timer_hold   = timer_hold_q;
    assign timer_clr    = timer_clr_q;
    assign sec_tick     = sec_tick_q;
    assign mole_mask    = mole_mask_q;
    assign score        = score_q;
    assign hit_pulse    = hit_q;
    assign miss_pulse   = miss_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// tb_whack_game_ctrl: directed self-checking bench for whack_game_ctrl (TICK_DIV=4).
module tb_whack_game_ctrl;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned MOLE_TICKS = 2;
    localparam logic [7:0]  SEED       = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start, pause_sw, timer_done;
    logic [3:0] btn;
    logic       timer_enable, timer_hold, timer_clr, sec_tick;
    logic [3:0] mole_mask, score;
    logic       hit_pulse, miss_pulse, game_over;

    int checks = 0;
    int errors = 0;

    // Reference state kept by the bench.
    logic [7:0] m_lfsr, m_prev;
    logic [1:0] exp_prev;
    logic [3:0] exp_mask;
    int         exp_score;
    int         div_m;
    logic       tick_m;
    logic       run_nx;

    whack_game_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .MOLE_TICKS (MOLE_TICKS),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pause_sw     (pause_sw),
        .btn          (btn),
        .timer_done   (timer_done),
        .timer_enable (timer_enable),
        .timer_hold   (timer_hold),
        .timer_clr    (timer_clr),
        .sec_tick     (sec_tick),
        .mole_mask    (mole_mask),
        .score        (score),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // m_prev holds the LFSR value that was current during the previous cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: update the divider model on the edge, return at the following negedge.
    task automatic step();
        @(posedge clk);
        tick_m = 1'b0;
        if (run_nx) begin
            if (div_m == int'(TICK_DIV) - 1) begin
                div_m  = 0;
                tick_m = 1'b1;
            end else begin
                div_m = div_m + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic expect_spawn(input string tag);
        logic [1:0] p;
        p = m_prev[1:0];
        if (p == exp_prev) p = p + 2'd1;
        exp_prev = p;
        exp_mask = 4'(4'b0001 << p);
        chk(tag, 8'(mole_mask), 8'(exp_mask));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hold"},   8'(timer_hold),   8'd1);
        chk({tag, "_enable"}, 8'(timer_enable), 8'd0);
        chk({tag, "_clr"},    8'(timer_clr),    8'd0);
        chk({tag, "_tick"},   8'(sec_tick),     8'd0);
        chk({tag, "_mask"},   8'(mole_mask),    8'd0);
        chk({tag, "_score"},  8'(score),        8'd0);
        chk({tag, "_hit"},    8'(hit_pulse),    8'd0);
        chk({tag, "_miss"},   8'(miss_pulse),   8'd0);
        chk({tag, "_over"},   8'(game_over),    8'd0);
    endtask

    initial begin
        start = 1'b0; pause_sw = 1'b0; timer_done = 1'b0; btn = 4'd0;
        run_nx = 1'b0; div_m = 0; tick_m = 1'b0; exp_prev = 2'd0; exp_mask = 4'd0;
        exp_score = 0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();
        chk("idle_clr", 8'(timer_clr), 8'd0);

        // Start edge: clear pulse and zero score one cycle after the rise.
        start = 1'b1;
        step();
        chk("start_clr",    8'(timer_clr),    8'd1);
        chk("start_score",  8'(score),        8'd0);
        chk("start_enable", 8'(timer_enable), 8'd1);
        chk("start_mask",   8'(mole_mask),    8'd0);
        start = 1'b0;
        run_nx = 1'b1;
        step();
        expect_spawn("spawn1");
        chk("clr_one_cycle", 8'(timer_clr), 8'd0);
        chk("tick_n2", 8'(sec_tick), 8'd0);
        step();
        chk("tick_n3", 8'(sec_tick), 8'd0);
        step();
        chk("tick_n4", 8'(sec_tick), 8'd0);
        chk("hold_n4", 8'(timer_hold), 8'd1);
        step();
        chk("tick_n5", 8'(sec_tick), 8'd1);
        chk("hold_n5", 8'(timer_hold), 8'd0);

        // Correct button -> hit.
        btn = exp_mask;
        step();
        exp_score = 1;
        chk("hit1_pulse", 8'(hit_pulse),  8'd1);
        chk("hit1_miss",  8'(miss_pulse), 8'd0);
        chk("hit1_score", 8'(score),      8'(exp_score));
        chk("hit1_mask",  8'(mole_mask),  8'd0);
        btn = 4'd0;
        step();
        expect_spawn("spawn2");

        // Wrong button -> miss, mole stays.
        btn = {exp_mask[2:0], exp_mask[3]};
        step();
        chk("wrong_miss",  8'(miss_pulse), 8'd1);
        chk("wrong_hit",   8'(hit_pulse),  8'd0);
        chk("wrong_score", 8'(score),      8'(exp_score));
        chk("wrong_mask",  8'(mole_mask),  8'(exp_mask));
        btn = 4'd0;

        // No press -> timeout on the second sec_tick.
        step();
        chk("to_tick1", 8'(sec_tick),   8'd1);
        chk("to_miss1", 8'(miss_pulse), 8'd0);
        repeat (3) step();
        chk("to_wait_miss", 8'(miss_pulse), 8'd0);
        chk("to_wait_mask", 8'(mole_mask),  8'(exp_mask));
        step();
        chk("to_tick2", 8'(sec_tick),   8'd1);
        chk("to_miss",  8'(miss_pulse), 8'd1);
        chk("to_mask",  8'(mole_mask),  8'd0);
        step();
        expect_spawn("spawn_after_timeout");

        // Fifteen more hits: score saturates at 15, hit_pulse keeps firing.
        for (int i = 0; i < 15; i++) begin
            btn = exp_mask;
            step();
            exp_score = (exp_score == 15) ? 15 : exp_score + 1;
            chk("loop_hit",   8'(hit_pulse), 8'd1);
            chk("loop_score", 8'(score),     8'(exp_score));
            btn = 4'd0;
            step();
            expect_spawn("loop_spawn");
        end
        chk("score_sat", 8'(score), 8'd15);

        // Pause for 20 cycles mid-mole; a button press inside the pause is ignored.
        pause_sw = 1'b1;
        run_nx = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5)  btn = exp_mask;
            if (i == 10) btn = 4'd0;
            step();
            chk("pause_tick",   8'(sec_tick),     8'd0);
            chk("pause_hold",   8'(timer_hold),   8'd1);
            chk("pause_mask",   8'(mole_mask),    8'(exp_mask));
            chk("pause_hit",    8'(hit_pulse),    8'd0);
            chk("pause_enable", 8'(timer_enable), 8'd1);
        end
        pause_sw = 1'b0;
        step();
        chk("unpause_mask", 8'(mole_mask), 8'(exp_mask));
        run_nx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("resume_tick", 8'(sec_tick),   8'(tick_m));
            chk("resume_mask", 8'(mole_mask),  8'(exp_mask));
            chk("resume_miss", 8'(miss_pulse), 8'd0);
        end

        // timer_done beats a simultaneous correct hit.
        btn = exp_mask;
        timer_done = 1'b1;
        run_nx = 1'b0;
        step();
        div_m = 0;
        chk("over_flag",   8'(game_over),    8'd1);
        chk("over_hit",    8'(hit_pulse),    8'd0);
        chk("over_miss",   8'(miss_pulse),   8'd0);
        chk("over_score",  8'(score),        8'd15);
        chk("over_mask",   8'(mole_mask),    8'd0);
        chk("over_enable", 8'(timer_enable), 8'd0);
        timer_done = 1'b0;
        btn = 4'd0;
        step();
        chk("over_held",       8'(game_over), 8'd1);
        chk("over_score_held", 8'(score),     8'd15);

        // Restart from OVER.
        start = 1'b1;
        step();
        exp_score = 0;
        chk("restart_clr",    8'(timer_clr),    8'd1);
        chk("restart_score",  8'(score),        8'd0);
        chk("restart_over",   8'(game_over),    8'd0);
        chk("restart_enable", 8'(timer_enable), 8'd1);
        start = 1'b0;
        run_nx = 1'b1;
        step();
        expect_spawn("spawn_restart");
        step();

        // Asynchronous reset mid-MOLE_UP.
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        run_nx = 1'b0;

        // timer_done has no effect in IDLE.
        timer_done = 1'b1;
        step();
        step();
        chk("idle_done_over",   8'(game_over),    8'd0);
        chk("idle_done_enable", 8'(timer_enable), 8'd0);
        chk("idle_done_hold",   8'(timer_hold),   8'd1);
        timer_done = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
